regfile_access_arbiter: RTL and testbench
=========================================

# regfile_access_arbiter

Round-robin arbiter that shares one CGRA register file (1 write port, 2 registered read ports) among NREQ requesters, typically neighbouring PEs or the config loader. Each cycle it grants at most one write and up to two reads, drives the register file's WE0/address/data pins, and routes the 1-cycle-late read data back to the correct requester with a valid strobe.

## Interface
- NREQ, 4: number of requesters (2..8)
- log2regs, 1: register-file address width
- size, 32: data width
- CGRA_Clock  in  1  clock
- CGRA_Reset  in  1  reset; asynchronous, active-high
- wr_req  in  NREQ  per-requester write request
- wr_addr  in  NREQ*log2regs  packed write addresses, requester i at slice i
- wr_data  in  NREQ*size  packed write data
- wr_gnt  out  NREQ  one-hot write grant (combinational)
- rd_req  in  NREQ  per-requester read request
- rd_addr  in  NREQ*log2regs  packed read addresses
- rd_gnt  out  NREQ  read grant, at most two bits set (combinational)
- rd_valid  out  NREQ  read data valid, one cycle after rd_gnt
- rd_data  out  NREQ*size  packed read data, valid where rd_valid set
- rf_WE0  out  1  register-file write enable
- rf_address_in0  out  log2regs  register-file write address
- rf_in0  out  size  register-file write data
- rf_address_out0, rf_address_out1  out  log2regs each  register-file read addresses
- rf_out0, rf_out1  in  size each  register-file read data (registered, 1-cycle latency)

## Operation
- Handshake: requester holds req and addr/data stable until its gnt bit is high; transfer happens on that rising edge; the requester drops or changes req the following cycle. Read and write paths are independent; one requester may hold both grants in the same cycle.
- Write arbitration: wptr (0..NREQ-1) marks the highest-priority index. Grant the first set wr_req at or after wptr, wrapping. rf_WE0 = |wr_gnt; rf_address_in0/rf_in0 are muxed from the winner, 0 when idle. On grant to i, wptr <= (i+1) mod NREQ; otherwise unchanged.
- Read arbitration: rptr as above. First winner A (search from rptr) uses port 0; second winner B (search from A+1, excluding A) uses port 1. Unused port address = 0. rptr <= (last winner + 1) mod NREQ; unchanged if no grant.
- Response pipeline: register port0/port1 owner index plus valid bits at the grant edge. Next cycle, rd_valid[owner] = 1 and rd_data slice = rf_out0 / rf_out1. Non-owned slices drive 0.
- While CGRA_Reset is high: all grants, rf_WE0 = 0; pointers, owner registers and rd_valid cleared.

## Timing
- Grant: same cycle as req (combinational from req and pointer).
- Read latency: grant at edge T, data presented in cycle T..T+1 (rd_valid high for exactly one cycle).
- Write visible to a read granted at a later edge; same-edge read returns the old value unless the bypass is compiled in.
- Reset values: rd_valid = 0, rd_data = 0, wptr = rptr = 0, all grants 0.
- Reset asserted mid-transfer: pending rd_valid is dropped; the requester must reissue.

## Configuration
- RFARB_BYPASS_EN defined: when a read and a write are granted on the same edge to the same address, capture wr data and a hit flag per port; the response returns the new write data instead of rf_outN.
- Undefined: no forwarding logic; same-edge read returns the pre-write register value.

## Structure
- Package cgra_rf_pkg: default NREQ, log2regs, size constants; function returning owner-index width.
- Sub-module rr_picker (req vector, start index, mask -> one-hot grant, index, any), instantiated three times: write, read port 0, read port 1.

## Test plan
- Single write: wr_req[2]=1, addr 1, data 0xA5A5_0001 -> wr_gnt=0100, rf_WE0=1, rf_address_in0=1; wptr becomes 3.
- Write contention: wr_req=1111 held 4 cycles from reset -> grants 0001, 0010, 0100, 1000 in order.
- Dual read: rd_req=0101, addrs 0 and 1 -> rd_gnt=0101, port0 to req0, port1 to req2; next cycle rd_valid=0101 with register values (1, 1 after reset).
- Triple read: rd_req=1110, rptr=0 -> first cycle grants 0110, second grants 1000; rptr ends at 0.
- Same-edge hazard: write 0x1234 to addr 0 and read addr 0 together -> response 0x1234 with RFARB_BYPASS_EN, 0x0000_0001 without.
- Reset mid-read: assert CGRA_Reset between grant and response -> rd_valid stays 0, pointers return to 0.

Source files
------------

// File: rtl/cgra_rf_pkg.sv
// Purpose : shared defaults and helpers for the CGRA register-file access arbiter.
// Latency : n/a (constants and a constant function only).
// Backpr. : n/a.
// Contents: default NREQ / log2regs / size, and owner_idx_w() which returns the
//           width needed to hold a requester index.
package cgra_rf_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int LOG2REGS_DEF = 1;
    localparam int SIZE_DEF     = 32;

    // Width of a requester index. It is never below 1 bit, so a 2-requester
    // build still gets a real vector.
    function automatic int owner_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Purpose : round-robin picker. It returns the first eligible requester at or after start_i, wrapping.
// Latency : combinational.
// Backpr. : none. Eligibility is req_i & mask_i and the caller owns any holding.
// Ports   : req_i   request vector        start_i  highest-priority index
//           mask_i  eligible requesters   gnt_o    one-hot winner
//           idx_o   winner index          any_o    a winner exists
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] eligible;

    assign eligible = req_i & mask_i;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        // Walk N slots starting at start_i. The first hit wins.
        for (int k = 0; k < N; k++) begin
            if (!any_o && eligible[(int'(start_i) + k) % N]) begin
                any_o = 1'b1;
                gnt_o[(int'(start_i) + k) % N] = 1'b1;
                idx_o = IW'((int'(start_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Purpose : round-robin sharing of one CGRA register file (1 write and 2 registered reads) among NREQ requesters.
// Latency : grants are combinational from the requests. Read data returns one cycle after the grant edge.
// Backpr. : a requester holds req, addr and data until its gnt bit is set. A requester that loses arbitration simply waits.
// Ports   : CGRA_Clock/CGRA_Reset (async, active-high) are the clock and reset.
//           wr_req/wr_addr/wr_data -> wr_gnt are the write side.
//           rd_req/rd_addr -> rd_gnt and rd_valid/rd_data are the read side.
//           rf_WE0/rf_address_in0/rf_in0 drive the write pins. rf_address_out0/1 drive the read addresses.
//           rf_out0/1 carry the registered read data.
// Config  : define RFARB_BYPASS_EN to forward write data to a read granted on the same edge to the same address.
module regfile_access_arbiter
    import cgra_rf_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int log2regs = LOG2REGS_DEF,
    parameter int size     = SIZE_DEF
) (
    input  logic                     CGRA_Clock,
    input  logic                     CGRA_Reset,
    input  logic [NREQ-1:0]          wr_req,
    input  logic [NREQ*log2regs-1:0] wr_addr,
    input  logic [NREQ*size-1:0]     wr_data,
    output logic [NREQ-1:0]          wr_gnt,
    input  logic [NREQ-1:0]          rd_req,
    input  logic [NREQ*log2regs-1:0] rd_addr,
    output logic [NREQ-1:0]          rd_gnt,
    output logic [NREQ-1:0]          rd_valid,
    output logic [NREQ*size-1:0]     rd_data,
    output logic                     rf_WE0,
    output logic [log2regs-1:0]      rf_address_in0,
    output logic [size-1:0]          rf_in0,
    output logic [log2regs-1:0]      rf_address_out0,
    output logic [log2regs-1:0]      rf_address_out1,
    input  logic [size-1:0]          rf_out0,
    input  logic [size-1:0]          rf_out1
);

    localparam int IW = owner_idx_w(NREQ);

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    logic [IW-1:0]   wptr_q, wptr_d;
    logic [IW-1:0]   rptr_q, rptr_d;
    logic [IW-1:0]   own0_q, own0_d, own1_q, own1_d;
    logic            v0_q, v0_d, v1_q, v1_d;

    logic [NREQ-1:0] wr_pick_gnt, rd0_pick_gnt, rd1_pick_gnt;
    logic [IW-1:0]   wr_idx, rd0_idx, rd1_idx, rd1_start;
    logic            wr_pick_any, rd0_pick_any, rd1_pick_any;
    logic            wr_any, rd0_any, rd1_any;
    logic [size-1:0] port0_dat, port1_dat;

    rr_picker #(.N(NREQ), .IW(IW)) u_wr_pick (
        .req_i   (wr_req),
        .start_i (wptr_q),
        .mask_i  ({NREQ{1'b1}}),
        .gnt_o   (wr_pick_gnt),
        .idx_o   (wr_idx),
        .any_o   (wr_pick_any)
    );

    rr_picker #(.N(NREQ), .IW(IW)) u_rd0_pick (
        .req_i   (rd_req),
        .start_i (rptr_q),
        .mask_i  ({NREQ{1'b1}}),
        .gnt_o   (rd0_pick_gnt),
        .idx_o   (rd0_idx),
        .any_o   (rd0_pick_any)
    );

    // The port-1 search starts just past the port-0 winner and excludes that winner.
    // With no port-0 winner, rd_req is all zero, so port 1 cannot win either.
    assign rd1_start = inc_wrap(rd0_idx);

    rr_picker #(.N(NREQ), .IW(IW)) u_rd1_pick (
        .req_i   (rd_req),
        .start_i (rd1_start),
        .mask_i  (~rd0_pick_gnt),
        .gnt_o   (rd1_pick_gnt),
        .idx_o   (rd1_idx),
        .any_o   (rd1_pick_any)
    );

    // Reset blocks every grant, so nothing is handed out while the pointers are being cleared.
    assign wr_any  = wr_pick_any  && !CGRA_Reset;
    assign rd0_any = rd0_pick_any && !CGRA_Reset;
    assign rd1_any = rd1_pick_any && !CGRA_Reset;
    assign wr_gnt  = CGRA_Reset ? '0 : wr_pick_gnt;
    assign rd_gnt  = CGRA_Reset ? '0 : (rd0_pick_gnt | rd1_pick_gnt);

    assign rf_WE0          = wr_any;
    assign rf_address_in0  = wr_any  ? wr_addr[int'(wr_idx)*log2regs +: log2regs] : '0;
    assign rf_in0          = wr_any  ? wr_data[int'(wr_idx)*size +: size]         : '0;
    assign rf_address_out0 = rd0_any ? rd_addr[int'(rd0_idx)*log2regs +: log2regs] : '0;
    assign rf_address_out1 = rd1_any ? rd_addr[int'(rd1_idx)*log2regs +: log2regs] : '0;

    always_comb begin
        wptr_d = wptr_q;
        if (wr_any) begin
            wptr_d = inc_wrap(wr_idx);
        end
        // The port-1 winner is later in round-robin order than the port-0 winner.
        // When port 1 is used, the pointer therefore moves past the port-1 winner.
        rptr_d = rptr_q;
        if (rd1_any) begin
            rptr_d = inc_wrap(rd1_idx);
        end else if (rd0_any) begin
            rptr_d = inc_wrap(rd0_idx);
        end
        own0_d = rd0_idx;
        own1_d = rd1_idx;
        v0_d   = rd0_any;
        v1_d   = rd1_any;
    end

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            own0_q <= '0;
            own1_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            own0_q <= own0_d;
            own1_q <= own1_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
        end
    end

`ifdef RFARB_BYPASS_EN
    // The register file returns the pre-write value for a read issued on the same edge as a write.
    // To return the new value instead, the write data is captured here together with a per-port hit flag.
    logic            hit0_q, hit0_d, hit1_q, hit1_d;
    logic [size-1:0] byp_q, byp_d;

    assign hit0_d = wr_any && rd0_any && (rf_address_in0 == rf_address_out0);
    assign hit1_d = wr_any && rd1_any && (rf_address_in0 == rf_address_out1);
    assign byp_d  = rf_in0;

    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            hit0_q <= 1'b0;
            hit1_q <= 1'b0;
            byp_q  <= '0;
        end else begin
            hit0_q <= hit0_d;
            hit1_q <= hit1_d;
            byp_q  <= byp_d;
        end
    end

    assign port0_dat = hit0_q ? byp_q : rf_out0;
    assign port1_dat = hit1_q ? byp_q : rf_out1;
`else
    assign port0_dat = rf_out0;
    assign port1_dat = rf_out1;
`endif

    // The two port owners are always different requesters, so at most one port matches each slice.
    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v0_q && int'(own0_q) == i) begin
                rd_valid[i]              = 1'b1;
                rd_data[i*size +: size]  = port0_dat;
            end else if (v1_q && int'(own1_q) == i) begin
                rd_valid[i]              = 1'b1;
                rd_data[i*size +: size]  = port1_dat;
            end
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Purpose : self-checking bench for regfile_access_arbiter with a behavioural register file and a response scoreboard.
// Latency : the monitor samples on the falling edge. Read responses are expected one cycle after the grant.
// Backpr. : n/a. The stimulus holds requests for whole cycles.
module tb_regfile_access_arbiter;

    localparam int NREQ  = 4;
    localparam int L     = 1;
    localparam int W     = 32;
    localparam int NREGS = 1 << L;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     wr_req;
    logic [NREQ*L-1:0]   wr_addr;
    logic [NREQ*W-1:0]   wr_data;
    logic [NREQ-1:0]     wr_gnt;
    logic [NREQ-1:0]     rd_req;
    logic [NREQ*L-1:0]   rd_addr;
    logic [NREQ-1:0]     rd_gnt;
    logic [NREQ-1:0]     rd_valid;
    logic [NREQ*W-1:0]   rd_data;
    logic                rf_WE0;
    logic [L-1:0]        rf_address_in0;
    logic [W-1:0]        rf_in0;
    logic [L-1:0]        rf_address_out0;
    logic [L-1:0]        rf_address_out1;
    logic [W-1:0]        rf_out0;
    logic [W-1:0]        rf_out1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t sb[$];

    regfile_access_arbiter #(.NREQ(NREQ), .log2regs(L), .size(W)) dut (
        .CGRA_Clock      (clk),
        .CGRA_Reset      (rst),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_gnt          (wr_gnt),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_gnt          (rd_gnt),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rf_WE0          (rf_WE0),
        .rf_address_in0  (rf_address_in0),
        .rf_in0          (rf_in0),
        .rf_address_out0 (rf_address_out0),
        .rf_address_out1 (rf_address_out1),
        .rf_out0         (rf_out0),
        .rf_out1         (rf_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural register file. Every register resets to 1, and a read returns the pre-write value one cycle later.
    logic [W-1:0] mem [NREGS];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= W'(1);
            rf_out0 <= '0;
            rf_out1 <= '0;
        end else begin
            rf_out0 <= mem[rf_address_out0];
            rf_out1 <= mem[rf_address_out1];
            if (rf_WE0) mem[rf_address_in0] <= rf_in0;
        end
    end

    function automatic int first_from(input logic [NREQ-1:0] v, input int s);
        for (int k = 0; k < NREQ; k++)
            if (v[(s + k) % NREQ]) return (s + k) % NREQ;
        return -1;
    endfunction

    // Reference model and scoreboard. Grants are checked against the model pointers.
    // Read responses are pushed at the grant and popped on the following cycle.
    int               wptr_m = 0;
    int               rptr_m = 0;
    int               wi, ra, rb;
    logic [NREQ-1:0]  exp_v, msk, eg;
    logic [NREQ*W-1:0] exp_d;
    logic [L-1:0]     e_ain, e_a0, e_a1;
    logic [W-1:0]     e_in, d0, d1;
    rsp_t             e;

    always @(negedge clk) begin
        if (rst) begin
            chk_eq("rst_wr_gnt", wr_gnt, 0);
            chk_eq("rst_rd_gnt", rd_gnt, 0);
            chk_eq("rst_we", rf_WE0, 0);
            chk_eq("rst_rd_valid", rd_valid, 0);
            chk_eq("rst_rd_data", rd_data, 0);
            wptr_m = 0;
            rptr_m = 0;
            sb.delete();
        end else begin
            exp_v = '0;
            exp_d = '0;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                exp_v[e.idx] = 1'b1;
                exp_d[e.idx*W +: W] = e.data;
            end
            chk_eq("rd_valid", rd_valid, exp_v);
            for (int i = 0; i < NREQ; i++)
                chk_eq($sformatf("rd_data%0d", i), rd_data[i*W +: W], exp_d[i*W +: W]);

            wi = first_from(wr_req, wptr_m);
            eg = '0;
            e_ain = '0;
            e_in = '0;
            if (wi >= 0) begin
                eg[wi] = 1'b1;
                e_ain = wr_addr[wi*L +: L];
                e_in = wr_data[wi*W +: W];
                wptr_m = (wi + 1) % NREQ;
            end
            chk_eq("wr_gnt", wr_gnt, eg);
            chk_eq("rf_we", rf_WE0, wi >= 0);
            chk_eq("rf_waddr", rf_address_in0, e_ain);
            chk_eq("rf_wdat", rf_in0, e_in);

            ra = first_from(rd_req, rptr_m);
            rb = -1;
            eg = '0;
            e_a0 = '0;
            e_a1 = '0;
            if (ra >= 0) begin
                msk = rd_req;
                msk[ra] = 1'b0;
                rb = first_from(msk, (ra + 1) % NREQ);
                eg[ra] = 1'b1;
                e_a0 = rd_addr[ra*L +: L];
                d0 = mem[e_a0];
`ifdef RFARB_BYPASS_EN
                if (wi >= 0 && e_ain == e_a0) d0 = e_in;
`endif
                e.idx = ra;
                e.data = d0;
                sb.push_back(e);
                rptr_m = (ra + 1) % NREQ;
            end
            if (rb >= 0) begin
                eg[rb] = 1'b1;
                e_a1 = rd_addr[rb*L +: L];
                d1 = mem[e_a1];
`ifdef RFARB_BYPASS_EN
                if (wi >= 0 && e_ain == e_a1) d1 = e_in;
`endif
                e.idx = rb;
                e.data = d1;
                sb.push_back(e);
                rptr_m = (rb + 1) % NREQ;
            end
            chk_eq("rd_gnt", rd_gnt, eg);
            chk_eq("rf_raddr0", rf_address_out0, e_a0);
            chk_eq("rf_raddr1", rf_address_out1, e_a1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        wr_req  = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = '0;
        rd_addr = '0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [W-1:0] hz_exp;

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (3) step();
        rst = 1'b0;

        // Single write to requester 2.
        wr_req = 4'b0100;
        wr_addr[2*L +: L] = 1'b1;
        wr_data[2*W +: W] = 32'hA5A5_0001;
        #2;
        chk_eq("single_wr_gnt", wr_gnt, 4'b0100);
        chk_eq("single_we", rf_WE0, 1);
        chk_eq("single_waddr", rf_address_in0, 1);
        chk_eq("single_wdat", rf_in0, 32'hA5A5_0001);
        step();
        wr_req = 4'b1111;
        #2 chk_eq("wptr_after_single", wr_gnt, 4'b1000);
        step();
        clear_in();

        // Write contention from reset.
        do_reset();
        wr_req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #2 chk_eq("contention", wr_gnt, 64'd1 << c);
            step();
        end
        clear_in();

        // Dual read.
        do_reset();
        rd_req = 4'b0101;
        rd_addr[0*L +: L] = 1'b0;
        rd_addr[2*L +: L] = 1'b1;
        #2;
        chk_eq("dual_rd_gnt", rd_gnt, 4'b0101);
        chk_eq("dual_addr0", rf_address_out0, 0);
        chk_eq("dual_addr1", rf_address_out1, 1);
        step();
        clear_in();
        #2;
        chk_eq("dual_valid", rd_valid, 4'b0101);
        chk_eq("dual_data0", rd_data[0*W +: W], 1);
        chk_eq("dual_data2", rd_data[2*W +: W], 1);

        // Triple read.
        do_reset();
        rd_req = 4'b1110;
        #2 chk_eq("triple_gnt1", rd_gnt, 4'b0110);
        step();
        rd_req = 4'b1000;
        #2 chk_eq("triple_gnt2", rd_gnt, 4'b1000);
        step();
        rd_req = 4'b1111;
        #2 chk_eq("triple_rptr0", rd_gnt, 4'b0011);
        step();
        clear_in();

        // Same-edge write/read hazard on address 0.
        do_reset();
        wr_req = 4'b0010;
        wr_data[1*W +: W] = 32'h0000_1234;
        rd_req = 4'b1000;
`ifdef RFARB_BYPASS_EN
        hz_exp = 32'h0000_1234;
`else
        hz_exp = 32'h0000_0001;
`endif
        step();
        clear_in();
        #2;
        chk_eq("hazard_valid", rd_valid, 4'b1000);
        chk_eq("hazard_data", rd_data[3*W +: W], hz_exp);

        // Reset between grant and response.
        do_reset();
        rd_req  = 4'b0001;
        rd_addr = '1;
        step();
        clear_in();
        rst = 1'b1;
        #2;
        chk_eq("rst_mid_valid", rd_valid, 0);
        chk_eq("rst_mid_data", rd_data, 0);
        step();
        rst = 1'b0;
        rd_req = 4'b1111;
        wr_req = 4'b1111;
        #2;
        chk_eq("rst_mid_rptr", rd_gnt, 4'b0011);
        chk_eq("rst_mid_wptr", wr_gnt, 4'b0001);
        step();
        clear_in();

        // Random traffic checked by the scoreboard.
        for (int t = 0; t < 300; t++) begin
            wr_req  = NREQ'($urandom);
            rd_req  = NREQ'($urandom);
            wr_addr = (NREQ*L)'($urandom);
            rd_addr = (NREQ*L)'($urandom);
            for (int i = 0; i < NREQ; i++) wr_data[i*W +: W] = $urandom;
            step();
        end
        clear_in();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
